// File: rtl/uart_apb_pkg.sv
// Shared types for the APB initiator that drives the uart_top register port.
// FSM state and response status encodings.
package uart_apb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        GAP    = 3'd3,
        RESP   = 3'd4
    } apb_mst_state_t;

    typedef enum logic [1:0] {
        OK             = 2'd0,
        SLVERR         = 2'd1,
        TIMEOUT        = 2'd2,
        POLL_EXHAUSTED = 2'd3
    } apb_rsp_status_t;

endpackage

// File: rtl/uart_apb_master_if.sv
// Command, response and APB signal bundle for uart_apb_master.
// master = initiator view, slave = controller plus APB target view.
interface uart_apb_master_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic              cmd_poll_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic [DATA_W-1:0] cmd_mask_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic [1:0]        rsp_status_o;
    logic              psel_o;
    logic              penable_o;
    logic              pwrite_o;
    logic [ADDR_W-1:0] paddr_o;
    logic [DATA_W-1:0] pwdata_o;
    logic [DATA_W-1:0] prdata_i;
    logic              pready_i;
    logic              pslverr_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_poll_i,
        input  cmd_addr_i, cmd_wdata_i, cmd_mask_i,
        input  rsp_ready_i, prdata_i, pready_i, pslverr_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o,
        output rsp_status_o, psel_o, penable_o,
        output pwrite_o, paddr_o, pwdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_poll_i,
        output cmd_addr_i, cmd_wdata_i, cmd_mask_i,
        output rsp_ready_i, prdata_i, pready_i, pslverr_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o,
        input  rsp_status_o, psel_o, penable_o,
        input  pwrite_o, paddr_o, pwdata_o
    );

endinterface

// File: rtl/uart_apb_master.sv
// APB initiator: one command at a time, wait-state watchdog, masked poll reads.
// One shared counter times both the pready watchdog and the poll gap.
module uart_apb_master
    import uart_apb_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256,
    parameter int POLL_GAP    = 10,
    parameter int POLL_MAX    = 1024
) (
    input logic clk_i,
    input logic reset_i,
    uart_apb_master_if.master bus
);

    localparam int CNT_MAX = (TIMEOUT_CYC > POLL_GAP) ? TIMEOUT_CYC : POLL_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(POLL_GAP - 1);
    localparam logic [31:0]      PMAX     = 32'(POLL_MAX);

    apb_mst_state_t    r_state;
    apb_mst_state_t    w_nxt;
    apb_rsp_status_t   r_status;
    apb_rsp_status_t   w_status;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt;
    logic [31:0]       r_rdcnt;
    logic [31:0]       w_rdcnt;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rdata;
    logic              r_write;
    logic              r_poll;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mask;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              w_accept;
    logic              w_miss;

    assign w_accept = bus.cmd_valid_i & r_cmd_ready;
    assign w_miss   = (bus.prdata_i & r_mask) != r_wdata;

    always_comb begin
        w_nxt    = r_state;
        w_status = r_status;
        w_rdata  = r_rdata;
        w_cnt    = r_cnt;
        w_rdcnt  = r_rdcnt;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nxt    = SETUP;
                    w_cnt    = '0;
                    w_rdcnt  = '0;
                    w_rdata  = '0;
                    w_status = OK;
                end
            end
            SETUP: begin
                w_nxt = ACCESS;
                w_cnt = '0;
            end
            ACCESS: begin
                if (bus.pready_i) begin
                    if (!r_write && r_rdcnt != '1)
                        w_rdcnt = r_rdcnt + 32'd1;
                    w_rdata = r_write ? '0 : bus.prdata_i;
                    if (bus.pslverr_i) begin
                        w_nxt    = RESP;
                        w_status = SLVERR;
                    end else if (r_poll && w_miss) begin
                        if (PMAX != 32'd0 && w_rdcnt >= PMAX) begin
                            w_nxt    = RESP;
                            w_status = POLL_EXHAUSTED;
                        end else begin
                            w_nxt = GAP;
                            w_cnt = '0;
                        end
                    end else begin
                        w_nxt    = RESP;
                        w_status = OK;
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_nxt    = RESP;
                    w_status = TIMEOUT;
                    w_rdata  = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) w_nxt = SETUP;
                else w_cnt = r_cnt + 1'b1;
            end
            RESP: begin
                if (bus.rsp_ready_i) w_nxt = IDLE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= IDLE;
            r_status    <= OK;
            r_cnt       <= '0;
            r_rdcnt     <= '0;
            r_rdata     <= '0;
            r_write     <= 1'b0;
            r_poll      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mask      <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            r_state     <= w_nxt;
            r_status    <= w_status;
            r_cnt       <= w_cnt;
            r_rdcnt     <= w_rdcnt;
            r_rdata     <= w_rdata;
            r_cmd_ready <= (w_nxt == IDLE);
            r_rsp_valid <= (w_nxt == RESP);
            r_psel      <= (w_nxt == SETUP) || (w_nxt == ACCESS);
            r_penable   <= (w_nxt == ACCESS);
            if (w_accept) begin
                r_write  <= bus.cmd_write_i;
                r_poll   <= bus.cmd_poll_i & ~bus.cmd_write_i;
                r_addr   <= bus.cmd_addr_i;
                r_wdata  <= bus.cmd_wdata_i;
                r_mask   <= bus.cmd_mask_i;
                r_paddr  <= bus.cmd_addr_i;
                r_pwrite <= bus.cmd_write_i;
                r_pwdata <= bus.cmd_write_i ? bus.cmd_wdata_i : '0;
            end else if (w_nxt == SETUP) begin
                // re-issue of a poll read after the gap
                r_paddr  <= r_addr;
                r_pwrite <= r_write;
                r_pwdata <= r_write ? r_wdata : '0;
            end else if (w_nxt != ACCESS) begin
                r_paddr  <= '0;
                r_pwrite <= 1'b0;
                r_pwdata <= '0;
            end
        end
    end

    assign bus.cmd_ready_o  = r_cmd_ready;
    assign bus.rsp_valid_o  = r_rsp_valid;
    assign bus.rsp_rdata_o  = r_rdata;
    assign bus.rsp_status_o = r_status;
    assign bus.psel_o       = r_psel;
    assign bus.penable_o    = r_penable;
    assign bus.pwrite_o     = r_pwrite;
    assign bus.paddr_o      = r_paddr;
    assign bus.pwdata_o     = r_pwdata;

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed bench for uart_apb_master against a stub APB target with
// programmable wait states, error injection and a loopback RX model.
module tb_uart_apb_master;
    import uart_apb_pkg::*;

    localparam logic [4:0] A_TXD  = 5'h00;
    localparam logic [4:0] A_RXD  = 5'h04;
    localparam logic [4:0] A_ST   = 5'h08;
    localparam logic [4:0] A_BAUD = 5'h0C;
    localparam logic [4:0] A_SCR  = 5'h10;

    logic clk_i = 1'b0;
    logic reset_i = 1'b0;
    always #5 clk_i = ~clk_i;

    uart_apb_master_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    uart_apb_master #(
        .ADDR_W(5), .DATA_W(32),
        .TIMEOUT_CYC(16), .POLL_GAP(3), .POLL_MAX(4)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .bus(bus)
    );

    // stub APB target
    logic        stuck = 1'b0;
    logic        err_mode = 1'b0;
    int          waits = 0;
    int          wcnt = 0;
    logic [31:0] mem [0:31];
    logic        rx_avail = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    int          rx_cd = 0;
    logic        acc;

    assign acc = bus.psel_o & bus.penable_o;
    assign bus.pready_i  = acc && !stuck && (wcnt == waits);
    assign bus.pslverr_i = bus.pready_i && err_mode;

    always_comb begin
        if (bus.paddr_o == A_ST)
            bus.prdata_i = {31'b0, rx_avail && (rx_cd == 0)};
        else if (bus.paddr_o == A_RXD)
            bus.prdata_i = {24'b0, rx_byte};
        else
            bus.prdata_i = mem[bus.paddr_o];
    end

    always @(posedge clk_i) begin
        if (acc && !bus.pready_i) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (bus.pready_i && !err_mode && bus.pwrite_o) begin
            if (bus.paddr_o == A_TXD) begin
                rx_byte  <= bus.pwdata_o[7:0];
                rx_avail <= 1'b1;
                rx_cd    <= 2;
            end else begin
                mem[bus.paddr_o] <= bus.pwdata_o;
            end
        end
        if (bus.pready_i && !bus.pwrite_o) begin
            if (bus.paddr_o == A_ST && rx_cd != 0) rx_cd <= rx_cd - 1;
            if (bus.paddr_o == A_RXD) rx_avail <= 1'b0;
        end
    end

    // bus monitor: free-running totals, bench works on deltas
    int          setup_tot = 0;
    int          pen_tot = 0;
    int          rsp_tot = 0;
    int          run = 0;
    int          last_gap = 0;
    logic [31:0] last_pwdata = '0;

    always @(posedge clk_i) begin
        if (bus.psel_o && !bus.penable_o) setup_tot <= setup_tot + 1;
        if (acc) begin
            pen_tot     <= pen_tot + 1;
            last_pwdata <= bus.pwdata_o;
        end
        if (bus.rsp_valid_o) rsp_tot <= rsp_tot + 1;
        if (bus.psel_o) begin
            if (run != 0) last_gap <= run;
            run <= 0;
        end else begin
            run <= run + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // cyc = cycle index after the accept edge in which rsp_valid_o is seen
    task automatic do_cmd(input logic w, input logic p,
                          input logic [4:0] a, input logic [31:0] d,
                          input logic [31:0] m, output int cyc,
                          output logic [1:0] st, output logic [31:0] rd,
                          output logic psel_at_rsp);
        int n;
        @(negedge clk_i);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = w;
        bus.cmd_poll_i  = p;
        bus.cmd_addr_i  = a;
        bus.cmd_wdata_i = d;
        bus.cmd_mask_i  = m;
        n = 0;
        while (!bus.cmd_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        @(posedge clk_i);
        #1;
        bus.cmd_valid_i = 1'b0;
        cyc = 1;
        while (!bus.rsp_valid_o && cyc < 200) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
        chk("rsp_seen", {31'b0, bus.rsp_valid_o}, 32'd1);
        st = bus.rsp_status_o;
        rd = bus.rsp_rdata_o;
        psel_at_rsp = bus.psel_o;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus.rsp_ready_i = 1'b0;
        chk("idle_after", {31'b0, bus.cmd_ready_o}, 32'd1);
    endtask

    int          cyc;
    logic [1:0]  st;
    logic [31:0] rd;
    logic        ps;
    int          s0;
    int          p0;
    int          r0;

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_poll_i  = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_wdata_i = '0;
        bus.cmd_mask_i  = '0;
        bus.rsp_ready_i = 1'b0;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", {31'b0, bus.cmd_ready_o}, 32'd1);
        chk("rst_psel", {31'b0, bus.psel_o}, 32'd0);
        chk("rst_pen", {31'b0, bus.penable_o}, 32'd0);
        chk("rst_rspv", {31'b0, bus.rsp_valid_o}, 32'd0);
        chk("rst_pwrite", {31'b0, bus.pwrite_o}, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b1;

        // zero-wait write: one SETUP, one ACCESS, response in cycle 3
        s0 = setup_tot; p0 = pen_tot;
        do_cmd(1'b1, 1'b0, A_BAUD, 32'h8, 32'h0, cyc, st, rd, ps);
        chk("wr_lat", cyc, 32'd3);
        chk("wr_st", {30'b0, st}, 32'd0);
        chk("wr_rd", rd, 32'd0);
        chk("wr_setup", setup_tot - s0, 32'd1);
        chk("wr_access", pen_tot - p0, 32'd1);
        chk("wr_pwdata", last_pwdata, 32'h8);

        do_cmd(1'b0, 1'b0, A_BAUD, 32'h0, 32'h0, cyc, st, rd, ps);
        chk("rb_rd", rd, 32'h8);
        chk("rb_st", {30'b0, st}, 32'd0);

        // three wait states
        do_cmd(1'b1, 1'b0, A_SCR, 32'hA5, 32'h0, cyc, st, rd, ps);
        waits = 3;
        p0 = pen_tot;
        do_cmd(1'b0, 1'b0, A_SCR, 32'h0, 32'h0, cyc, st, rd, ps);
        chk("ws_access", pen_tot - p0, 32'd4);
        chk("ws_lat", cyc, 32'd6);
        chk("ws_rd", rd, 32'hA5);
        chk("ws_st", {30'b0, st}, 32'd0);
        waits = 0;

        // slave error
        err_mode = 1'b1;
        do_cmd(1'b0, 1'b0, A_SCR, 32'h0, 32'h0, cyc, st, rd, ps);
        chk("se_st", {30'b0, st}, 32'd1);
        chk("se_psel", {31'b0, ps}, 32'd0);
        err_mode = 1'b0;

        // watchdog
        stuck = 1'b1;
        p0 = pen_tot;
        do_cmd(1'b0, 1'b0, A_SCR, 32'h0, 32'h0, cyc, st, rd, ps);
        chk("to_st", {30'b0, st}, 32'd2);
        chk("to_rd", rd, 32'd0);
        chk("to_access", pen_tot - p0, 32'd16);
        chk("to_lat", cyc, 32'd18);
        stuck = 1'b0;
        do_cmd(1'b1, 1'b0, A_SCR, 32'h3C, 32'h0, cyc, st, rd, ps);
        chk("to_next_st", {30'b0, st}, 32'd0);
        chk("to_next_lat", cyc, 32'd3);

        // poll succeeds on the third status read
        do_cmd(1'b1, 1'b0, A_TXD, 32'h5A, 32'h0, cyc, st, rd, ps);
        s0 = setup_tot;
        do_cmd(1'b0, 1'b1, A_ST, 32'h1, 32'h1, cyc, st, rd, ps);
        chk("poll_st", {30'b0, st}, 32'd0);
        chk("poll_rd", rd, 32'h1);
        chk("poll_reads", setup_tot - s0, 32'd3);
        chk("poll_gap", last_gap, 32'd3);
        do_cmd(1'b0, 1'b0, A_RXD, 32'h0, 32'h0, cyc, st, rd, ps);
        chk("rx_rd", rd, 32'h5A);

        // poll exhausted
        s0 = setup_tot;
        do_cmd(1'b0, 1'b1, A_ST, 32'h1, 32'h1, cyc, st, rd, ps);
        chk("ex_st", {30'b0, st}, 32'd3);
        chk("ex_reads", setup_tot - s0, 32'd4);
        chk("ex_rd", rd, 32'd0);

        // async reset in ACCESS
        stuck = 1'b1;
        @(negedge clk_i);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_poll_i  = 1'b0;
        bus.cmd_addr_i  = A_SCR;
        @(posedge clk_i);
        #1;
        bus.cmd_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("pre_rst_pen", {31'b0, bus.penable_o}, 32'd1);
        #2;
        reset_i = 1'b0;
        #1;
        chk("ar_psel", {31'b0, bus.psel_o}, 32'd0);
        chk("ar_pen", {31'b0, bus.penable_o}, 32'd0);
        chk("ar_rspv", {31'b0, bus.rsp_valid_o}, 32'd0);
        r0 = rsp_tot;
        @(negedge clk_i);
        reset_i = 1'b1;
        stuck = 1'b0;
        repeat (20) @(posedge clk_i);
        #1;
        chk("ar_ready", {31'b0, bus.cmd_ready_o}, 32'd1);
        chk("ar_no_rsp", rsp_tot - r0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
